// File: rtl/tone_sequencer.sv
// Plays a fixed 16-note melody as a square wave whose amplitude follows a 3-bit volume.
// Beat ticks step through the note ROM; audio is a registered copy of the current sample.
module tone_sequencer #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        music_en,
  input  logic        beat_tick,
  input  logic        up_pulse,
  input  logic        down_pulse,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic [2:0]  volume,
  output logic [3:0]  note_idx,
  output logic        playing
);

  typedef enum logic {IDLE, PLAY} state_t;

  // Rounded half-period: round(CLK_HZ / (2*f)) done in integer arithmetic.
  function automatic logic [17:0] half_period(input int freq);
    return 18'((CLK_HZ + freq) / (2 * freq));
  endfunction

  localparam logic [17:0] HP_C4 = half_period(262);
  localparam logic [17:0] HP_D4 = half_period(294);
  localparam logic [17:0] HP_E4 = half_period(330);
  localparam logic [17:0] HP_F4 = half_period(349);
  localparam logic [17:0] HP_G4 = half_period(392);
  localparam logic [17:0] HP_A4 = half_period(440);
  localparam logic [17:0] HP_B4 = half_period(494);
  localparam logic [17:0] HP_C5 = half_period(523);

  state_t      state;
  state_t      state_next;
  logic [17:0] hp;
  logic [17:0] counter;
  logic        phase;
  logic [15:0] amp;
  logic [15:0] sample;
  logic [15:0] audio_q;

  always_comb begin
    hp = '0;
    case (note_idx)
      4'd0:  hp = HP_C4;
      4'd1:  hp = HP_D4;
      4'd2:  hp = HP_E4;
      4'd3:  hp = HP_F4;
      4'd4:  hp = HP_G4;
      4'd5:  hp = HP_A4;
      4'd6:  hp = HP_B4;
      4'd7:  hp = HP_C5;
      4'd8:  hp = HP_C5;
      4'd9:  hp = HP_B4;
      4'd10: hp = HP_A4;
      4'd11: hp = HP_G4;
      4'd12: hp = HP_F4;
      4'd13: hp = HP_E4;
      4'd14: hp = HP_D4;
      default: hp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (music_en)  state_next = PLAY;
      PLAY: if (!music_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    playing = (state == PLAY);
  end

  // Entering PLAY restarts the melody; a beat_tick on that same edge is deliberately ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_idx <= '0;
      counter  <= '0;
      phase    <= 1'b1;
    end else if (state == IDLE) begin
      if (music_en) begin
        note_idx <= '0;
        counter  <= '0;
        phase    <= 1'b1;
      end
    end else if (beat_tick) begin
      note_idx <= note_idx + 4'd1;
      counter  <= '0;
      phase    <= 1'b1;
    end else if (hp == '0) begin
      counter <= '0;
      phase   <= 1'b1;
    end else if (counter == hp - 18'd1) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + 18'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume <= 3'd3;
    end else if (up_pulse && !down_pulse && volume != 3'd7) begin
      volume <= volume + 3'd1;
    end else if (down_pulse && !up_pulse && volume != 3'd0) begin
      volume <= volume - 3'd1;
    end
  end

  always_comb begin
    amp    = {1'b0, volume, 12'h000};
    sample = '0;
    if (state == PLAY && hp != '0) sample = phase ? amp : -amp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) audio_q <= '0;
    else        audio_q <= sample;
  end

  assign audio_left  = audio_q;
  assign audio_right = audio_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a cycle-level model built from note start times
// and volume arithmetic predicts every output, plus directed checks on the key timing points.
module tb_tone_sequencer;

  localparam int CLK_HZ = 1_000_000;
  localparam int HP_C4  = 1908;

  logic        clk;
  logic        rst_n;
  logic        music_en;
  logic        beat_tick;
  logic        up_pulse;
  logic        down_pulse;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic [2:0]  volume;
  logic [3:0]  note_idx;
  logic        playing;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: time spent in the current note determines the phase.
  int          freq_tab [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                                 523, 494, 440, 392, 349, 330, 294, 0};
  bit          m_play;
  int          m_idx;
  int          m_t;
  int          m_vol;
  logic [15:0] m_audio;
  logic [39:0] obs;

  tone_sequencer #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .music_en   (music_en),
    .beat_tick  (beat_tick),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .volume     (volume),
    .note_idx   (note_idx),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hp_of(input int idx);
    if (freq_tab[idx] == 0) return 0;
    return $rtoi(real'(CLK_HZ) / (2.0 * real'(freq_tab[idx])) + 0.5);
  endfunction

  function automatic logic [15:0] model_sample();
    int hp;
    int amp;
    hp  = hp_of(m_idx);
    amp = m_vol * 4096;
    if (!m_play || hp == 0) return 16'h0000;
    if (((m_t / hp) % 2) == 0) return 16'(amp);
    return 16'(-amp);
  endfunction

  function automatic logic [39:0] model_vec();
    return {m_audio, m_audio, 3'(m_vol), 4'(m_idx), m_play};
  endfunction

  task automatic model_reset();
    m_play  = 1'b0;
    m_idx   = 0;
    m_t     = 0;
    m_vol   = 3;
    m_audio = 16'h0000;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return 1 time unit after it.
  task automatic step(input bit en, input bit beat, input bit up, input bit down);
    logic [15:0] nxt;
    music_en   = en;
    beat_tick  = beat;
    up_pulse   = up;
    down_pulse = down;
    @(posedge clk);
    nxt = model_sample();
    if (!m_play) begin
      if (en) begin
        m_play = 1'b1;
        m_idx  = 0;
        m_t    = 0;
      end
    end else begin
      if (beat) begin
        m_idx = (m_idx + 1) % 16;
        m_t   = 0;
      end else begin
        m_t++;
      end
      if (!en) m_play = 1'b0;
    end
    if (up && !down && m_vol < 7) m_vol++;
    else if (down && !up && m_vol > 0) m_vol--;
    m_audio = nxt;
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    music_en   = 1'b0;
    beat_tick  = 1'b0;
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    music_en   = 1'b0;
    beat_tick  = 1'b0;
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    obs = {audio_left, audio_right, volume, note_idx, playing};
    n_cmp++;
    if (obs !== {16'h0000, 16'h0000, 3'd3, 4'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %h want %h", obs, {16'h0000, 16'h0000, 3'd3, 4'd0, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_volume();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (volume !== 3'd7) begin
      n_fail++;
      $display("[TB] FAIL volume_sat_high: got %0d want 7", volume);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL volume_down %0d: got %h want %h", i, obs, model_vec());
      end
    end
    n_cmp++;
    if (volume !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL volume_sat_low: got %0d want 0", volume);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (volume !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL volume_both_at_0: got %0d want 0", volume);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (volume !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL volume_both_mid: got %0d want 2", volume);
    end
  endtask

  task automatic test_tone_timing();
    int high_run;
    bit seen_low;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    high_run = 0;
    seen_low = 1'b0;
    for (int i = 1; i <= 4 * HP_C4 + 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL tone cycle %0d: got %h want %h", i, obs, model_vec());
      end
      if (audio_left == 16'hD000) seen_low = 1'b1;
      if (!seen_low && audio_left == 16'h3000) high_run++;
    end
    n_cmp++;
    if (high_run != HP_C4) begin
      n_fail++;
      $display("[TB] FAIL tone_first_half: got %0d cycles want %0d", high_run, HP_C4);
    end
  endtask

  task automatic test_beat_wrap();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 15; b++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, (k == 0), 1'b0, 1'b0);
        obs = {audio_left, audio_right, volume, note_idx, playing};
        n_cmp++;
        if (obs !== model_vec()) begin
          n_fail++;
          $display("[TB] FAIL beat %0d cyc %0d: got %h want %h", b, k, obs, model_vec());
        end
      end
    end
    n_cmp++;
    if (note_idx !== 4'd15 || audio_left !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL beat_rest: got idx %0d audio %h want idx 15 audio 0000", note_idx, audio_left);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (note_idx !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL beat_wrap_idx: got %0d want 0", note_idx);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (audio_left !== 16'h3000 || audio_right !== 16'h3000) begin
      n_fail++;
      $display("[TB] FAIL beat_wrap_audio: got %h/%h want 3000", audio_left, audio_right);
    end
    for (int i = 0; i < HP_C4 + 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL wrap_restart cycle %0d: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_enable_toggle();
    int high_run;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (playing !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_playing: got %b want 0", playing);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (audio_left !== 16'h0000 || audio_right !== 16'h0000 || note_idx !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL drop_idle: got audio %h idx %0d want 0000 idx 2", audio_left, note_idx);
    end
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (note_idx !== 4'd0 || playing !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reenable: got idx %0d playing %b want idx 0 playing 1", note_idx, playing);
    end
    high_run = 0;
    for (int i = 0; i < HP_C4 + 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL reenable cycle %0d: got %h want %h", i, obs, model_vec());
      end
      if (audio_left == 16'h3000) high_run++;
    end
    n_cmp++;
    if (high_run != HP_C4) begin
      n_fail++;
      $display("[TB] FAIL reenable_half: got %0d cycles want %0d", high_run, HP_C4);
    end
  endtask

  task automatic test_mid_note_volume();
    int low_run;
    logic [15:0] after_up;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    low_run  = 0;
    after_up = 16'h0000;
    for (int i = 1; i <= 2 * HP_C4 + 50; i++) begin
      step(1'b1, 1'b0, (i == HP_C4 + 100), 1'b0);
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL midvol cycle %0d: got %h want %h", i, obs, model_vec());
      end
      if (audio_left[15]) low_run++;
      if (i == HP_C4 + 101) after_up = audio_left;
    end
    n_cmp++;
    if (after_up !== 16'hC000) begin
      n_fail++;
      $display("[TB] FAIL midvol_sample: got %h want c000", after_up);
    end
    n_cmp++;
    if (low_run != HP_C4) begin
      n_fail++;
      $display("[TB] FAIL midvol_low_phase: got %0d cycles want %0d", low_run, HP_C4);
    end
  endtask

  task automatic test_random();
    bit en;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) en = ~en;
      step(en, ($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 49) == 0));
      obs = {audio_left, audio_right, volume, note_idx, playing};
      n_cmp++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (100) step(1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {audio_left, audio_right, volume, note_idx, playing};
    n_cmp++;
    if (obs !== {16'h0000, 16'h0000, 3'd3, 4'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %h want %h", obs, {16'h0000, 16'h0000, 3'd3, 4'd0, 1'b0});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (audio_left !== 16'h3000 || playing !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_play: got %h playing %b want 3000 playing 1", audio_left, playing);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    music_en   = 1'b0;
    beat_tick  = 1'b0;
    up_pulse   = 1'b0;
    down_pulse = 1'b0;
    model_reset();
    test_reset();
    test_volume();
    test_tone_timing();
    test_beat_wrap();
    test_enable_toggle();
    test_mid_note_volume();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
